cmd_issuer: RTL and testbench

- Command processor that drives the navigation state machine's handshake from the initiator side.
- Accepts 16-bit commands from the UART/BLE wrapper (cmd, cmd_rdy) and decodes calibrate, heading, move and solve opcodes.
- Issues one-cycle strt_cal/strt_hdng/strt_mv pulses with stable desired-heading and stop qualifiers, then waits for cal_done or mv_cmplt before sending a response.
- A watchdog aborts the wait if the responder never completes.

---
 rtl/nav_cmd_pkg.sv | 26 ++
 rtl/cmd_wdog.sv | 30 +++
 rtl/cmd_issuer.sv | 151 +++++++++++++++
 tb/tb_cmd_issuer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nav_cmd_pkg.sv
// rtl/nav_cmd_pkg.sv - shared opcode, state and field definitions for the navigation command issuer
package nav_cmd_pkg;

    typedef enum logic [2:0] {
        OP_CAL   = 3'b000,
        OP_HDNG  = 3'b001,
        OP_MOVE  = 3'b010,
        OP_SOLVE = 3'b011
    } opcode_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WT_CAL  = 3'd1,
        WT_HDNG = 3'd2,
        WT_MV   = 3'd3,
        SOLVING = 3'd4
    } state_t;

    localparam int OPC_MSB      = 15;
    localparam int OPC_LSB      = 13;
    localparam int HDNG_MSB     = 11;
    localparam int HDNG_LSB     = 0;
    localparam int STP_LFT_BIT  = 1;
    localparam int STP_RGHT_BIT = 0;

endpackage

// File: rtl/cmd_wdog.sv
// rtl/cmd_wdog.sv - saturating wait watchdog for the command issuer
module cmd_wdog #(
    parameter int TMO_W = 24
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic expired
);

    localparam logic [TMO_W-1:0] CNT_MAX = '1;

    logic [TMO_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || !en) begin
            cnt <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

    // High in the cycle whose closing edge takes the counter to all-ones,
    // so the registered tmo_err lines up with the counter reaching its limit.
    assign expired = en && !clr && (cnt == (CNT_MAX - 1'b1));

endmodule

// File: rtl/cmd_issuer.sv
// rtl/cmd_issuer.sv - command decoder and initiator-side handshake FSM for the navigator
module cmd_issuer
    import nav_cmd_pkg::*;
#(
    parameter int TMO_W  = 24,
    parameter int HDNG_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       cmd,
    input  logic              cmd_rdy,
    output logic              clr_cmd_rdy,
    output logic              send_resp,
    output logic              strt_cal,
    input  logic              cal_done,
    output logic              strt_hdng,
    output logic              strt_mv,
    output logic              stp_lft,
    output logic              stp_rght,
    output logic [HDNG_W-1:0] dsrd_hdng,
    input  logic              mv_cmplt,
    output logic              cmd_md,
    input  logic              sol_cmplt,
    output logic              tmo_err
);

    state_t state, state_nxt;

    logic              clr_nxt, resp_nxt, cal_nxt, hdng_nxt, mv_nxt, tmo_nxt;
    logic              lft_nxt, rght_nxt, md_nxt;
    logic [HDNG_W-1:0] hdng_val_nxt;
    logic              wd_en, wd_clr, wd_expired;
    logic [2:0]        opc;

    assign opc   = cmd[OPC_MSB:OPC_LSB];
    assign wd_en = (state == WT_CAL) || (state == WT_HDNG) || (state == WT_MV);

    cmd_wdog #(
        .TMO_W (TMO_W)
    ) u_wdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (wd_en),
        .clr     (wd_clr),
        .expired (wd_expired)
    );

    always_comb begin
        state_nxt    = state;
        clr_nxt      = 1'b0;
        resp_nxt     = 1'b0;
        cal_nxt      = 1'b0;
        hdng_nxt     = 1'b0;
        mv_nxt       = 1'b0;
        tmo_nxt      = 1'b0;
        lft_nxt      = stp_lft;
        rght_nxt     = stp_rght;
        hdng_val_nxt = dsrd_hdng;
        md_nxt       = cmd_md;
        wd_clr       = 1'b0;

        case (state)
            IDLE: begin
                // The source still holds cmd_rdy while clr_cmd_rdy is high.
                if (cmd_rdy && !clr_cmd_rdy) begin
                    clr_nxt = 1'b1;
                    case (opc)
                        OP_CAL: begin
                            cal_nxt   = 1'b1;
                            wd_clr    = 1'b1;
                            state_nxt = WT_CAL;
                        end
                        OP_HDNG: begin
                            hdng_val_nxt = HDNG_W'(cmd[HDNG_MSB:HDNG_LSB]);
                            hdng_nxt     = 1'b1;
                            wd_clr       = 1'b1;
                            state_nxt    = WT_HDNG;
                        end
                        OP_MOVE: begin
                            lft_nxt   = cmd[STP_LFT_BIT];
                            rght_nxt  = cmd[STP_RGHT_BIT];
                            mv_nxt    = 1'b1;
                            wd_clr    = 1'b1;
                            state_nxt = WT_MV;
                        end
                        OP_SOLVE: begin
                            md_nxt    = 1'b0;
                            state_nxt = SOLVING;
                        end
                        default: ;
                    endcase
                end
            end
            WT_CAL: begin
                if (cal_done) begin
                    resp_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else if (wd_expired) begin
                    tmo_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WT_HDNG, WT_MV: begin
                if (mv_cmplt) begin
                    resp_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else if (wd_expired) begin
                    tmo_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            SOLVING: begin
                if (sol_cmplt) begin
                    md_nxt    = 1'b1;
                    resp_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            clr_cmd_rdy <= 1'b0;
            send_resp   <= 1'b0;
            strt_cal    <= 1'b0;
            strt_hdng   <= 1'b0;
            strt_mv     <= 1'b0;
            stp_lft     <= 1'b0;
            stp_rght    <= 1'b0;
            dsrd_hdng   <= '0;
            cmd_md      <= 1'b1;
            tmo_err     <= 1'b0;
        end else begin
            state       <= state_nxt;
            clr_cmd_rdy <= clr_nxt;
            send_resp   <= resp_nxt;
            strt_cal    <= cal_nxt;
            strt_hdng   <= hdng_nxt;
            strt_mv     <= mv_nxt;
            stp_lft     <= lft_nxt;
            stp_rght    <= rght_nxt;
            dsrd_hdng   <= hdng_val_nxt;
            cmd_md      <= md_nxt;
            tmo_err     <= tmo_nxt;
        end
    end

endmodule

// File: tb/tb_cmd_issuer.sv
// tb/tb_cmd_issuer.sv - scoreboard bench for cmd_issuer with randomized commands and completions
module tb_cmd_issuer;

    localparam int TMO_W  = 6;
    localparam int HDNG_W = 12;
    localparam int LIMIT  = (1 << TMO_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [15:0]       cmd;
    logic              cmd_rdy, cal_done, mv_cmplt, sol_cmplt;
    logic              clr_cmd_rdy, send_resp, strt_cal, strt_hdng, strt_mv;
    logic              stp_lft, stp_rght, cmd_md, tmo_err;
    logic [HDNG_W-1:0] dsrd_hdng;

    cmd_issuer #(.TMO_W(TMO_W), .HDNG_W(HDNG_W)) dut (
        .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_rdy(cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp), .strt_cal(strt_cal),
        .cal_done(cal_done), .strt_hdng(strt_hdng), .strt_mv(strt_mv),
        .stp_lft(stp_lft), .stp_rght(stp_rght), .dsrd_hdng(dsrd_hdng),
        .mv_cmplt(mv_cmplt), .cmd_md(cmd_md), .sol_cmplt(sol_cmplt), .tmo_err(tmo_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // pulse vector: {clr_cmd_rdy, strt_cal, strt_hdng, strt_mv, send_resp, tmo_err}
    typedef struct {
        int         t;
        logic [5:0] p;
        logic [11:0] hd;
        logic       sl;
        logic       sr;
        logic       md;
    } ev_t;

    ev_t exp_q[$];
    int checks = 0;
    int failures = 0;

    logic [11:0] m_hd;
    logic        m_sl, m_sr, m_md;

    task automatic push(input int t, input logic [5:0] p);
        ev_t e;
        e.t = t; e.p = p; e.hd = m_hd; e.sl = m_sl; e.sr = m_sr; e.md = m_md;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin : monitor
        logic [5:0] obs;
        ev_t e;
        obs = {clr_cmd_rdy, strt_cal, strt_hdng, strt_mv, send_resp, tmo_err};
        if (|obs[4:2]) begin
            checks++;
            if ($countones(obs[4:2]) > 1) begin
                failures++;
                $display("FAIL strt_onehot cyc=%0d got=%b required=one-hot", cyc, obs[4:2]);
            end
        end
        if (obs != 6'b0) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pulse cyc=%0d got=%b required=none", cyc, obs);
            end else begin
                e = exp_q.pop_front();
                if (e.t != cyc || e.p != obs || e.hd != dsrd_hdng || e.sl != stp_lft ||
                    e.sr != stp_rght || e.md != cmd_md) begin
                    failures++;
                    $display("FAIL event cyc=%0d req_cyc=%0d pulses=%b req=%b hd=%h req=%h stp=%b%b req=%b%b md=%b req=%b",
                             cyc, e.t, obs, e.p, dsrd_hdng, e.hd, stp_lft, stp_rght, e.sl, e.sr, cmd_md, e.md);
                end
            end
        end
    end

    task automatic check_reset_outputs(input string name);
        logic [20:0] got, req;
        got = {clr_cmd_rdy, send_resp, strt_cal, strt_hdng, strt_mv, stp_lft, stp_rght, cmd_md, tmo_err, dsrd_hdng};
        req = {8'b0000_0001, 1'b0, 12'h000};
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end
    endtask

    function automatic int rnd(input int lo, input int hi);
        return int'($urandom_range(hi, lo));
    endfunction

    // dly < 0: random completion; dly == 0: never completes; dly > 0: completion sampled dly edges after acceptance.
    task automatic run_cmd(input logic [15:0] c, input bit early, input bit pre_next,
                           input logic [15:0] nxt, input int dly, output bit did_pre);
        int t0, e, res, r, se;
        bit has_c, sk, comp, stray;
        logic [2:0] op;
        logic [5:0] p;
        did_pre = 1'b0;
        op = c[15:13];
        if (!early) begin
            cmd = c;
            cmd_rdy = 1'b1;
        end
        t0 = cyc + 1;
        case (op)
            3'd0: p = 6'b110000;
            3'd1: begin m_hd = c[11:0]; p = 6'b101000; end
            3'd2: begin m_sl = c[1]; m_sr = c[0]; p = 6'b100100; end
            3'd3: begin m_md = 1'b0; p = 6'b100000; end
            default: p = 6'b100000;
        endcase
        push(t0, p);
        @(posedge clk);
        @(posedge clk);
        #1 cmd_rdy = 1'b0;
        if (op > 3'd3) return;

        has_c = 1'b1;
        if (op == 3'd3) begin
            e = t0 + ((dly > 0) ? dly : rnd(2, 40));
        end else begin
            if (dly < 0) begin
                r = rnd(0, 3);
                if (r == 0) has_c = 1'b0;
                else if (r == 1) e = t0 + LIMIT;
                else e = t0 + rnd(2, LIMIT);
            end else if (dly == 0) begin
                has_c = 1'b0;
            end else begin
                e = t0 + dly;
            end
            if (!has_c || e > t0 + LIMIT) begin
                has_c = 1'b0;
                e = t0 + LIMIT;
            end
        end
        res = e;
        se = t0 + rnd(2, 20);
        sk = 1'($urandom_range(1, 0));

        for (int j = t0 + 1; j < res; j++) begin
            comp  = has_c && (j + 1 == res);
            stray = (j + 1 == se);
            cal_done  = (op == 3'd0 && comp) || (op != 3'd0 && stray && !sk);
            mv_cmplt  = ((op == 3'd1 || op == 3'd2) && comp) ||
                        ((op == 3'd0 || op == 3'd3) && stray && sk);
            sol_cmplt = (op == 3'd3 && comp) || (op != 3'd3 && stray && (op == 3'd0 ? !sk : sk));
            if (pre_next && j == t0 + 2) begin
                cmd = nxt;
                cmd_rdy = 1'b1;
                did_pre = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        cal_done = 1'b0; mv_cmplt = 1'b0; sol_cmplt = 1'b0;
        if (has_c) begin
            if (op == 3'd3) m_md = 1'b1;
            push(res, 6'b000010);
        end else begin
            push(res, 6'b000001);
        end
    endtask

    task automatic idle_gap();
        int g;
        g = rnd(0, 4);
        for (int k = 0; k < g; k++) begin
            cal_done  = 1'($urandom_range(1, 0));
            mv_cmplt  = 1'($urandom_range(1, 0));
            sol_cmplt = 1'($urandom_range(1, 0));
            @(posedge clk);
            #1;
        end
        cal_done = 1'b0; mv_cmplt = 1'b0; sol_cmplt = 1'b0;
    endtask

    function automatic logic [15:0] rand_cmd();
        logic [15:0] r;
        r = 16'($urandom);
        r[15:13] = 3'($urandom_range(7, 0));
        return r;
    endfunction

    initial begin
        bit did, early;
        logic [15:0] c, nxt;
        int t0;
        rst_n = 1'b0; cmd = 16'h0; cmd_rdy = 1'b0;
        cal_done = 1'b0; mv_cmplt = 1'b0; sol_cmplt = 1'b0;
        m_hd = 12'h0; m_sl = 1'b0; m_sr = 1'b0; m_md = 1'b1;
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("reset_state");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_cmd(16'h23FF, 1'b0, 1'b0, 16'h0, 40, did);
        run_cmd(16'h4002, 1'b0, 1'b1, 16'h4001, 20, did);
        run_cmd(16'h4001, did, 1'b0, 16'h0, 10, did);
        run_cmd(16'h0000, 1'b0, 1'b0, 16'h0, 25, did);
        run_cmd(16'h6000, 1'b0, 1'b0, 16'h0, 30, did);
        run_cmd(16'h2123, 1'b0, 1'b0, 16'h0, 0, did);
        run_cmd(16'h2456, 1'b0, 1'b0, 16'h0, LIMIT, did);
        run_cmd(16'hE123, 1'b0, 1'b0, 16'h0, -1, did);
        run_cmd(16'h0000, 1'b0, 1'b0, 16'h0, 5, did);

        early = 1'b0;
        c = rand_cmd();
        for (int i = 0; i < 60; i++) begin
            nxt = rand_cmd();
            run_cmd(c, early, ($urandom_range(3, 0) == 0), nxt, -1, did);
            early = did;
            c = nxt;
            if (!early) idle_gap();
        end
        if (early) run_cmd(c, 1'b1, 1'b0, 16'h0, -1, did);

        // reset while waiting on a move
        cmd = 16'h4003; cmd_rdy = 1'b1;
        t0 = cyc + 1;
        m_sl = 1'b1; m_sr = 1'b1;
        push(t0, 6'b100100);
        @(posedge clk);
        @(posedge clk);
        #1 cmd_rdy = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 check_reset_outputs("reset_mid_wait");
        m_hd = 12'h0; m_sl = 1'b0; m_sr = 1'b0; m_md = 1'b1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // reset coinciding with a command drops the strt pulse
        cmd = 16'h2ABC; cmd_rdy = 1'b1; rst_n = 1'b0;
        @(posedge clk);
        #1 check_reset_outputs("reset_drops_strt");
        rst_n = 1'b1; cmd_rdy = 1'b0;
        @(posedge clk);
        #1;
        run_cmd(16'h0000, 1'b0, 1'b0, 16'h0, 6, did);
        run_cmd(16'h2ABC, 1'b0, 1'b0, 16'h0, 8, did);

        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_events got=%0d pending required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
